// File: rtl/counter_sequencer.sv
// Prescaled up-counter with LOAD/START/STOP/CLEAR command port, one-shot terminal count.
// Define COUNTER_SEQ_AUTORELOAD_EN to wrap to 0 and keep running at terminal count instead.
module counter_sequencer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_data,
  output logic [CNT_W-1:0] cnt,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] oe
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } state_t;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_START = 2'b01;
  localparam logic [1:0] OP_STOP  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [CNT_W-1:0]   presc_reg, presc_next;
  logic [CNT_W-1:0]   div_reg, div_next;
  logic [CNT_W-1:0]   limit_reg, limit_next;
  logic               done_reg, done_next;
  logic               accept;
  logic               tick;
  logic [CNT_W-1:0]   cnt_inc;

  assign accept  = ena & cmd_valid;
  assign tick    = (state_reg == RUN) && (presc_reg == div_reg);
  assign cnt_inc = cnt_reg + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      presc_reg <= '0;
      div_reg   <= '0;
      limit_reg <= '1;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      presc_reg <= presc_next;
      div_reg   <= div_next;
      limit_reg <= limit_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    presc_next = presc_reg;
    div_next   = div_reg;
    limit_next = limit_reg;
    done_next  = done_reg;
    if (ena) begin
      done_next = 1'b0;
      // CLEAR and STOP pre-empt a coincident tick entirely (no increment, no done).
      if (accept && cmd_op == OP_CLEAR) begin
        state_next = IDLE;
        cnt_next   = '0;
        presc_next = '0;
      end else if (accept && cmd_op == OP_STOP && state_reg == RUN) begin
        state_next = PAUSE;
      end else begin
        if (accept && cmd_op == OP_LOAD)
          limit_next = cmd_data;
        if (state_reg == RUN)
          presc_next = tick ? '0 : presc_reg + 1'b1;
        if (tick) begin
          cnt_next = cnt_inc;
          // Terminal test uses the limit as updated by a same-cycle LOAD.
          if (cnt_inc == limit_next) begin
            done_next = 1'b1;
`ifdef COUNTER_SEQ_AUTORELOAD_EN
            cnt_next = '0;
`else
            state_next = IDLE;
`endif
          end
        end
        if (accept && cmd_op == OP_START) begin
          div_next = cmd_data;
          if (state_reg == IDLE) begin
            state_next = RUN;
            presc_next = '0;
          end else if (state_reg == PAUSE) begin
            state_next = RUN;
          end
        end
      end
    end
  end

  assign cmd_ready = ena;
  assign cnt       = cnt_reg;
  assign busy      = (state_reg == RUN);
  assign done      = done_reg;
  assign oe        = {CNT_W{state_reg != IDLE}};

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer: a rule-level model checked every cycle plus literal checkpoints.
// Build with COUNTER_SEQ_AUTORELOAD_EN defined to exercise the auto-reload variant.
module tb_counter_sequencer;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ena;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [W-1:0] cmd_data;
  logic [W-1:0] cnt;
  logic         busy;
  logic         done;
  logic [W-1:0] oe;

  counter_sequencer #(.CNT_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cnt(cnt), .busy(busy), .done(done), .oe(oe)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: mode 0=idle, 1=running, 2=paused; rules applied in command-priority order.
  int           m_mode;
  logic [W-1:0] m_cnt, m_presc, m_div, m_limit;
  logic         m_done;

  task automatic model_reset();
    m_mode = 0; m_cnt = '0; m_presc = '0; m_div = '0; m_limit = '1; m_done = 1'b0;
  endtask

  task automatic model_step();
    int           mode0;
    bit           fire;
    logic [W-1:0] nv;
    mode0  = m_mode;
    fire   = (m_mode == 1) && (m_presc == m_div);
    m_done = 1'b0;
    if (cmd_valid && cmd_op == 2'b11) begin
      m_mode = 0; m_cnt = '0; m_presc = '0;
      return;
    end
    if (cmd_valid && cmd_op == 2'b10 && m_mode == 1) begin
      m_mode = 2;
      return;
    end
    if (cmd_valid && cmd_op == 2'b00) m_limit = cmd_data;
    if (mode0 == 1) m_presc = fire ? '0 : m_presc + 1'b1;
    if (fire) begin
      nv = m_cnt + 1'b1;
      if (nv == m_limit) begin
        m_done = 1'b1;
`ifdef COUNTER_SEQ_AUTORELOAD_EN
        m_cnt = '0;
`else
        m_cnt = nv;
        m_mode = 0;
`endif
      end else begin
        m_cnt = nv;
      end
    end
    if (cmd_valid && cmd_op == 2'b01) begin
      m_div = cmd_data;
      if (mode0 == 0) begin m_mode = 1; m_presc = '0; end
      else if (mode0 == 2) m_mode = 1;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else if (ena) model_step();
  end

  always @(negedge clk) begin
    chk("cyc_cnt", 32'(cnt), 32'(m_cnt));
    chk("cyc_busy", 32'(busy), 32'(m_mode == 1));
    chk("cyc_done", 32'(done), 32'(m_done));
    chk("cyc_oe", 32'(oe), (m_mode != 0) ? 32'hFF : 32'h0);
    chk("cyc_ready", 32'(cmd_ready), 32'(ena));
  end

  task automatic cmd(input logic [1:0] op, input logic [W-1:0] data);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = data;
    @(posedge clk); #2;
    $display("cmd op=%0d data=%0d ena=%0b -> cnt=%0d busy=%0b done=%0b", op, data, ena, cnt, busy, done);
    cmd_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = '0;
    idle(3);
    chk("rst_cnt", 32'(cnt), 32'd0);
    chk("rst_oe", 32'(oe), 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    idle(1);
`ifndef COUNTER_SEQ_AUTORELOAD_EN
    // LOAD 3, START div=0: one increment per cycle, one-shot stop at 3
    cmd(2'b00, 8'd3);
    cmd(2'b01, 8'd0);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_oe", 32'(oe), 32'hFF);
    idle(1); chk("t1_cnt1", 32'(cnt), 32'd1);
    idle(1); chk("t1_cnt2", 32'(cnt), 32'd2);
    idle(1); chk("t1_cnt3", 32'(cnt), 32'd3);
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_idle", 32'(busy), 32'd0);
    idle(1); chk("t1_done_pulse", 32'(done), 32'd0);
    chk("t1_hold", 32'(cnt), 32'd3);

    // LOAD 2, START div=3: first increment 4 edges after START
    cmd(2'b11, 8'd0);
    cmd(2'b00, 8'd2);
    cmd(2'b01, 8'd3);
    idle(3); chk("t2_pre", 32'(cnt), 32'd0);
    idle(1); chk("t2_first", 32'(cnt), 32'd1);
    idle(3); chk("t2_mid", 32'(cnt), 32'd1);
    idle(1); chk("t2_second", 32'(cnt), 32'd2);
    chk("t2_done", 32'(done), 32'd1);

    // Pause at 2 (STOP on a tick cycle), resume, done at 5
    cmd(2'b11, 8'd0);
    cmd(2'b00, 8'd5);
    cmd(2'b01, 8'd0);
    idle(2); chk("t3_cnt2", 32'(cnt), 32'd2);
    cmd(2'b10, 8'd0);
    chk("t3_stop_cnt", 32'(cnt), 32'd2);
    chk("t3_stop_busy", 32'(busy), 32'd0);
    idle(10);
    chk("t3_pause_cnt", 32'(cnt), 32'd2);
    chk("t3_pause_oe", 32'(oe), 32'hFF);
    cmd(2'b01, 8'd0);
    chk("t3_resume", 32'(busy), 32'd1);
    idle(3);
    chk("t3_cnt5", 32'(cnt), 32'd5);
    chk("t3_done", 32'(done), 32'd1);

    // ena low for 6 edges mid-run: frozen, commands ignored
    cmd(2'b11, 8'd0);
    cmd(2'b00, 8'd200);
    cmd(2'b01, 8'd1);
    idle(5); chk("t4_before", 32'(cnt), 32'd2);
    ena = 1'b0;
    chk("t4_ready", 32'(cmd_ready), 32'd0);
    cmd(2'b11, 8'd0);
    cmd(2'b00, 8'd9);
    cmd(2'b01, 8'd0);
    idle(3);
    chk("t4_frozen_cnt", 32'(cnt), 32'd2);
    chk("t4_frozen_busy", 32'(busy), 32'd1);
    ena = 1'b1;
    idle(1); chk("t4_resume", 32'(cnt), 32'd3);

    // Reset mid-run at cnt=7
    idle(8); chk("t5_cnt7", 32'(cnt), 32'd7);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_cnt", 32'(cnt), 32'd0);
    chk("t5_rst_oe", 32'(oe), 32'h0);
    chk("t5_rst_done", 32'(done), 32'd0);
    idle(2);
    rst_n = 1'b1;
    idle(4);
    chk("t5_no_resume", 32'(busy), 32'd0);
    chk("t5_cnt0", 32'(cnt), 32'd0);

    // CLEAR on a terminal tick: no increment, no done
    cmd(2'b00, 8'd1);
    cmd(2'b01, 8'd0);
    cmd(2'b11, 8'd0);
    chk("t6_clr_cnt", 32'(cnt), 32'd0);
    chk("t6_clr_done", 32'(done), 32'd0);

    // LOAD on a tick compares against the new limit
    cmd(2'b00, 8'd9);
    cmd(2'b01, 8'd0);
    idle(1); chk("t7_cnt1", 32'(cnt), 32'd1);
    cmd(2'b00, 8'd2);
    chk("t7_cnt2", 32'(cnt), 32'd2);
    chk("t7_done", 32'(done), 32'd1);

    // START with cnt == limit: done only after a full wrap
    cmd(2'b01, 8'd0);
    idle(255);
    chk("t8_wrap_cnt", 32'(cnt), 32'd1);
    chk("t8_no_done", 32'(done), 32'd0);
    idle(1);
    chk("t8_cnt", 32'(cnt), 32'd2);
    chk("t8_done", 32'(done), 32'd1);
`else
    // LOAD 0, START div=0: done every 256 cycles, stays running
    cmd(2'b00, 8'd0);
    cmd(2'b01, 8'd0);
    idle(255);
    chk("ar_cnt255", 32'(cnt), 32'd255);
    chk("ar_no_done", 32'(done), 32'd0);
    idle(1);
    chk("ar_cnt0", 32'(cnt), 32'd0);
    chk("ar_done1", 32'(done), 32'd1);
    chk("ar_busy1", 32'(busy), 32'd1);
    idle(1);
    chk("ar_pulse", 32'(done), 32'd0);
    idle(255);
    chk("ar_done2", 32'(done), 32'd1);
    chk("ar_busy2", 32'(busy), 32'd1);
`endif
    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
